// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the framing UART transmitter.
// UART_FRAME_TX_PARITY_EN adds an even-parity bit to every byte.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHead,
    StData,
    StCsum
  } frame_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  localparam logic [7:0] HeaderDefault = 8'hAA;

  // Bit period minus one at 50 MHz
  localparam int unsigned BaudEnd9600   = 5207;
  localparam int unsigned BaudEnd115200 = 433;

  localparam int unsigned BitIdxW = 4;

`ifdef UART_FRAME_TX_PARITY_EN
  localparam int unsigned FrameBits = 11;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  localparam int unsigned FrameBits = 10;
`endif

endpackage

// File: rtl/uart_frame_tx_byte.sv
// Single-byte serialiser: start, d[0]..d[7], optional parity, stop.
// UART_FRAME_TX_PARITY_EN inserts even parity before the stop bit.
module uart_byte_tx
  import uart_frame_pkg::*;
#(
  parameter int unsigned CntBaudEnd = BaudEnd9600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       done_o,
  output logic       tx_o
);

  localparam int unsigned CntW   = (CntBaudEnd > 0) ? $clog2(CntBaudEnd + 1) : 1;
  localparam int unsigned ShiftW = FrameBits - 1;
  localparam logic [CntW-1:0]    CntEnd  = CntW'(CntBaudEnd);
  localparam logic [BitIdxW-1:0] LastBit = BitIdxW'(FrameBits - 1);

  logic                active_q, active_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BitIdxW-1:0]  bit_idx_q, bit_idx_d;
  logic [ShiftW-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic [ShiftW-1:0]   load_bits;
  logic                bit_end;

`ifdef UART_FRAME_TX_PARITY_EN
  assign load_bits = {1'b1, even_parity(data_i), data_i};
`else
  assign load_bits = {1'b1, data_i};
`endif

  assign bit_end = active_q && (cnt_q == CntEnd);
  assign done_o  = bit_end && (bit_idx_q == LastBit);
  // Accepting in the final stop-bit cycle lets the next start bit follow with no gap
  assign ready_o = !active_q || done_o;
  assign tx_o    = tx_q;

  always_comb begin
    active_d  = active_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    if (start_i && ready_o) begin
      active_d  = 1'b1;
      cnt_d     = '0;
      bit_idx_d = '0;
      shift_d   = load_bits;
      tx_d      = 1'b0;
    end else if (done_o) begin
      active_d  = 1'b0;
      cnt_d     = '0;
      bit_idx_d = '0;
      tx_d      = 1'b1;
    end else if (bit_end) begin
      cnt_d     = '0;
      bit_idx_d = bit_idx_q + BitIdxW'(1);
      tx_d      = shift_q[0];
      shift_d   = {1'b1, shift_q[ShiftW-1:1]};
    end else if (active_q) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q  <= 1'b0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '1;
      tx_q      <= 1'b1;
    end else begin
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Framing UART transmitter: payload FIFO plus framing FSM emitting header, payload, checksum.
// UART_FRAME_TX_PARITY_EN selects 8E1 bytes instead of 8N1.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int unsigned CNT_BAUD_END = BaudEnd9600,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [7:0]  HEADER       = HeaderDefault
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_vld,
  input  logic       din_last,
  output logic       din_rdy,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(FIFO_DEPTH);

  // Payload FIFO
  fifo_entry_t     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            rdy_q, rdy_d;
  logic            push, pop, empty;
  fifo_entry_t     head;

  assign push    = din_vld && rdy_q;
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign din_rdy = rdy_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
    rdy_d = (count_d != Full);
  end

  always_ff @(posedge sclk) begin
    if (push) mem_q[wr_ptr_q] <= '{last: din_last, data: din};
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
    end
  end

  // Framing FSM
  frame_state_e state_q, state_d;
  logic [7:0]   csum_q, csum_d;
  logic         last_seen_q, last_seen_d;
  logic         frame_done_q, frame_done_d;
  logic         byte_start, byte_ready, byte_done;
  logic [7:0]   byte_data;

  always_comb begin
    state_d      = state_q;
    csum_d       = csum_q;
    last_seen_d  = last_seen_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    byte_start   = 1'b0;
    byte_data    = HEADER;
    unique case (state_q)
      StIdle: begin
        csum_d      = '0;
        last_seen_d = 1'b0;
        if (!empty) begin
          byte_start = 1'b1;
          state_d    = StHead;
        end
      end
      StHead, StData: begin
        // Byte boundary; with nothing queued and no last seen, the line idles high
        if (byte_ready) begin
          if (last_seen_q) begin
            byte_start = 1'b1;
            byte_data  = csum_q;
            state_d    = StCsum;
          end else if (!empty) begin
            pop         = 1'b1;
            byte_start  = 1'b1;
            byte_data   = head.data;
            csum_d      = csum_q + head.data;
            last_seen_d = head.last;
            state_d     = StData;
          end else begin
            state_d = StData;
          end
        end
      end
      StCsum: begin
        if (byte_done) begin
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q      <= StIdle;
      csum_q       <= '0;
      last_seen_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      csum_q       <= csum_d;
      last_seen_q  <= last_seen_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;
  assign busy       = (state_q != StIdle) || frame_done_q;

  uart_byte_tx #(
    .CntBaudEnd(CNT_BAUD_END)
  ) u_byte_tx (
    .clk_i  (sclk),
    .rst_i  (rst),
    .start_i(byte_start),
    .data_i (byte_data),
    .ready_o(byte_ready),
    .done_o (byte_done),
    .tx_o   (tx)
  );

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: decodes tx and compares with a frame-level model.
// Build with UART_FRAME_TX_PARITY_EN to check the parity variant.
module tb_uart_frame_tx;

  localparam int BaudEnd = 3;
  localparam int BitCyc  = BaudEnd + 1;
`ifdef UART_FRAME_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int ByteCyc = NB * BitCyc;

  logic       sclk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_vld = 1'b0;
  logic       din_last = 1'b0;
  logic       din_rdy, tx, busy, frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fd_count = 0;
  int fd_cycle = 0;
  int pushed = 0;
  int first_full = -1;
  int push_timeouts = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];
  bit         rx_ok[$];
  bit         rx_par[$];
  logic [7:0] pl_q[$];
  logic [7:0] exp_q[$];

  uart_frame_tx #(
    .CNT_BAUD_END(BaudEnd),
    .FIFO_DEPTH  (16),
    .HEADER      (8'hAA)
  ) dut (
    .sclk      (sclk),
    .rst       (rst),
    .din       (din),
    .din_vld   (din_vld),
    .din_last  (din_last),
    .din_rdy   (din_rdy),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  always @(negedge sclk) begin
    if (frame_done === 1'b1) begin
      fd_count = fd_count + 1;
      fd_cycle = cyc;
    end
  end

  // Line decoder: sample every cycle, require each bit constant for BitCyc cycles
  initial begin : decoder
    logic [NB-1:0] bits;
    logic first, s;
    bit clean;
    int t0;
    forever begin
      @(negedge sclk);
      if (rst === 1'b0 && tx === 1'b0) begin
        t0 = cyc;
        clean = 1'b1;
        bits = '0;
        first = 1'b0;
        for (int b = 0; b < NB; b++) begin
          for (int c = 0; c < BitCyc; c++) begin
            if (b != 0 || c != 0) @(negedge sclk);
            s = tx;
            if (c == 0) first = s;
            else if (s !== first) clean = 1'b0;
          end
          bits[b] = first;
        end
        if (bits[NB-1] !== 1'b1) clean = 1'b0;
`ifdef UART_FRAME_TX_PARITY_EN
        if (bits[9] !== ^bits[8:1]) clean = 1'b0;
        rx_par.push_back(bits[9]);
`endif
        rx_q.push_back(bits[8:1]);
        rx_t.push_back(t0);
        rx_ok.push_back(clean);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Reference model: header, payload as given, then payload sum mod 256
  task automatic append_frame();
    logic [7:0] sum;
    sum = 8'h00;
    exp_q.push_back(8'hAA);
    foreach (pl_q[i]) begin
      exp_q.push_back(pl_q[i]);
      sum = sum + pl_q[i];
    end
    exp_q.push_back(sum);
  endtask

  task automatic flush_rx();
    rx_q.delete();
    rx_t.delete();
    rx_ok.delete();
    rx_par.delete();
  endtask

  task automatic push_byte(input logic [7:0] b, input logic l);
    int w;
    @(negedge sclk);
    din = b;
    din_last = l;
    din_vld = 1'b1;
    w = 0;
    while (din_rdy !== 1'b1 && w < 5000) begin
      if (first_full < 0) first_full = pushed;
      @(negedge sclk);
      w++;
    end
    @(posedge sclk);
    #1;
    din_vld = 1'b0;
    din_last = 1'b0;
    if (w < 5000) pushed++;
    else push_timeouts++;
  endtask

  task automatic push_frame(input int max_gap);
    for (int i = 0; i < pl_q.size(); i++) begin
      push_byte(pl_q[i], i == pl_q.size() - 1);
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge sclk);
    end
  endtask

  task automatic wait_frames(input int target, output bit ok);
    int w;
    w = 0;
    while (fd_count < target && w < 20000) begin
      @(negedge sclk);
      w++;
    end
    ok = (fd_count >= target);
    repeat (3) @(negedge sclk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge sclk);
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done);
    end
    checks++;
    if (din_rdy !== 1'b1) begin errors++; $display("FAIL reset_din_rdy: got %b want 1", din_rdy); end
    rst = 1'b0;
    repeat (2) @(negedge sclk);
  endtask

  task automatic test_basic();
    bit ok;
    int fd0;
    flush_rx();
    exp_q.delete();
    pl_q = '{8'h01, 8'h02, 8'h03};
    append_frame();
    fd0 = fd_count;
    push_frame(0);
    wait_frames(fd0 + 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: frame_done count %0d want %0d", fd_count, fd0 + 1); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_count: got %0d bytes want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin
        errors++;
        $display("FAIL basic_byte%0d: got %02h framing_ok=%0d want %02h", i, rx_q[i], rx_ok[i], exp_q[i]);
      end
      if (i > 0) begin
        checks++;
        if (rx_t[i] - rx_t[i-1] != ByteCyc) begin
          errors++; $display("FAIL basic_gap%0d: got %0d want %0d", i, rx_t[i] - rx_t[i-1], ByteCyc);
        end
      end
    end
    if (rx_t.size() > 0) begin
      checks++;
      if (fd_cycle - rx_t[0] != 5 * ByteCyc) begin
        errors++; $display("FAIL basic_done_time: got %0d want %0d", fd_cycle - rx_t[0], 5 * ByteCyc);
      end
    end
    checks++;
    if (fd_count - fd0 != 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", fd_count - fd0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    bit ok;
    flush_rx();
    exp_q.delete();
    pl_q = '{8'hFF, 8'h02};
    append_frame();
    push_frame(0);
    wait_frames(fd_count + 1, ok);
    checks++;
    if (!ok || rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wrap_count: got %0d bytes want %0d (done=%0d)", rx_q.size(), exp_q.size(), ok);
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin
        errors++;
        $display("FAIL wrap_byte%0d: got %02h framing_ok=%0d want %02h", i, rx_q[i], rx_ok[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    flush_rx();
    exp_q.delete();
    pl_q.delete();
    for (int i = 0; i < 20; i++) pl_q.push_back(8'($urandom));
    append_frame();
    pushed = 0;
    first_full = -1;
    push_timeouts = 0;
    push_frame(0);
    checks++;
    if (first_full != 16) begin errors++; $display("FAIL bp_full_at: got %0d want 16", first_full); end
    checks++;
    if (push_timeouts != 0 || pushed != 20) begin
      errors++; $display("FAIL bp_accepted: got %0d want 20 (timeouts %0d)", pushed, push_timeouts);
    end
    wait_frames(fd_count + 1, ok);
    checks++;
    if (!ok || rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_count: got %0d bytes want %0d (done=%0d)", rx_q.size(), exp_q.size(), ok);
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin
        errors++;
        $display("FAIL bp_byte%0d: got %02h framing_ok=%0d want %02h", i, rx_q[i], rx_ok[i], exp_q[i]);
      end
    end
    checks++;
    if (din_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_after: got %b want 1", din_rdy); end
  endtask

  task automatic test_underrun();
    bit ok;
    int busy_low, tx_low;
    flush_rx();
    exp_q.delete();
    pl_q = '{8'h10, 8'h20};
    append_frame();
    push_byte(8'h10, 1'b0);
    busy_low = 0;
    tx_low = 0;
    repeat (4) @(negedge sclk);
    for (int i = 0; i < 196; i++) begin
      @(negedge sclk);
      if (busy !== 1'b1) busy_low++;
      if (i >= 3 * ByteCyc && tx !== 1'b1) tx_low++;
    end
    checks++;
    if (busy_low != 0) begin errors++; $display("FAIL underrun_busy: got %0d low cycles want 0", busy_low); end
    checks++;
    if (tx_low != 0) begin errors++; $display("FAIL underrun_idle_tx: got %0d low cycles want 0", tx_low); end
    push_byte(8'h20, 1'b1);
    wait_frames(fd_count + 1, ok);
    checks++;
    if (!ok || rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL underrun_count: got %0d bytes want %0d (done=%0d)", rx_q.size(), exp_q.size(), ok);
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin
        errors++;
        $display("FAIL underrun_byte%0d: got %02h framing_ok=%0d want %02h", i, rx_q[i], rx_ok[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t0, w;
    flush_rx();
    push_byte(8'h55, 1'b0);
    push_byte(8'h66, 1'b1);
    w = 0;
    while (tx !== 1'b0 && w < 1000) begin
      @(negedge sclk);
      w++;
    end
    t0 = cyc;
    // Third data bit (d[2]) of the first payload byte
    while (cyc < t0 + ByteCyc + 3 * BitCyc + 1) @(negedge sclk);
    rst = 1'b1;
    @(posedge sclk);
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++;
    if (din_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_din_rdy: got %b want 1", din_rdy); end
    rst = 1'b0;
    repeat (ByteCyc + 10) @(negedge sclk);
    flush_rx();
    repeat (3 * ByteCyc) @(negedge sclk);
    checks++;
    if (rx_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_fifo_flushed: got %0d bytes busy=%b want 0 bytes", rx_q.size(), busy);
    end
    exp_q.delete();
    pl_q = '{8'h07};
    append_frame();
    push_frame(0);
    wait_frames(fd_count + 1, ok);
    checks++;
    if (!ok || rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rstmid_count: got %0d bytes want %0d (done=%0d)", rx_q.size(), exp_q.size(), ok);
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin
        errors++;
        $display("FAIL rstmid_byte%0d: got %02h framing_ok=%0d want %02h", i, rx_q[i], rx_ok[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int fd0;
    flush_rx();
    exp_q.delete();
    fd0 = fd_count;
    pl_q.delete();
    for (int i = 0; i < 3; i++) pl_q.push_back(8'($urandom));
    append_frame();
    push_frame(0);
    pl_q.delete();
    for (int i = 0; i < 2; i++) pl_q.push_back(8'($urandom));
    append_frame();
    push_frame(0);
    wait_frames(fd0 + 2, ok);
    checks++;
    if (!ok || rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d bytes want %0d (done=%0d)", rx_q.size(), exp_q.size(), ok);
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d: got %02h framing_ok=%0d want %02h", i, rx_q[i], rx_ok[i], exp_q[i]);
      end
    end
    if (rx_t.size() > 5) begin
      checks++;
      if (rx_t[5] - rx_t[4] != ByteCyc + 1) begin
        errors++; $display("FAIL b2b_idle_gap: got %0d want %0d", rx_t[5] - rx_t[4], ByteCyc + 1);
      end
    end
    checks++;
    if (fd_count - fd0 != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", fd_count - fd0); end
  endtask

  task automatic test_random();
    bit ok;
    int len;
    for (int f = 0; f < 4; f++) begin
      flush_rx();
      exp_q.delete();
      pl_q.delete();
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom));
      append_frame();
      push_frame(60);
      wait_frames(fd_count + 1, ok);
      checks++;
      if (!ok || rx_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d bytes want %0d (done=%0d)", f, rx_q.size(), exp_q.size(), ok);
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin
          errors++;
          $display("FAIL rand%0d_byte%0d: got %02h framing_ok=%0d want %02h", f, i, rx_q[i], rx_ok[i],
                   exp_q[i]);
        end
      end
    end
  endtask

`ifdef UART_FRAME_TX_PARITY_EN
  task automatic test_parity();
    bit ok;
    bit exp_par;
    flush_rx();
    exp_q.delete();
    pl_q = '{8'h01};
    append_frame();
    push_frame(0);
    wait_frames(fd_count + 1, ok);
    checks++;
    if (!ok || rx_par.size() != 3) begin
      errors++; $display("FAIL parity_count: got %0d bytes want 3 (done=%0d)", rx_par.size(), ok);
    end
    for (int i = 0; i < 3 && i < rx_par.size(); i++) begin
      exp_par = ^exp_q[i];
      checks++;
      if (rx_par[i] !== exp_par || rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL parity_byte%0d: got %02h par %0d want %02h par %0d", i, rx_q[i], rx_par[i], exp_q[i],
                 exp_par);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_underrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef UART_FRAME_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
